// File: rtl/pic_pkg.sv
// Shared constants and types for the interrupt controller slice.
package pic_pkg;

  localparam int PIC_NUM_IRQ = 8;

  localparam logic TRIG_EDGE  = 1'b0;
  localparam logic TRIG_LEVEL = 1'b1;

  typedef logic [2:0] irq_idx_t;

endpackage

// File: rtl/irq_line_filter.sv
// One IR line: multi-flop synchroniser followed by a stability counter
// that only accepts a level change after FILTER_CYCLES consecutive cycles.
module irq_line_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ir,
  output logic filt
);

  localparam int CNT_W = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would
  // collapse the synchroniser chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], ir};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  generate
    if (FILTER_CYCLES == 0) begin : g_bypass
      assign filt = sync;
    end else begin : g_filter
      logic [CNT_W-1:0] cnt_q;
      logic             filt_q;

      // The counter never passes FILTER_CYCLES-1: reaching the threshold
      // accepts the new level and restarts, so it is inherently saturated.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q  <= '0;
          filt_q <= 1'b0;
        end else if (sync == filt_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
          filt_q <= sync;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end

      assign filt = filt_q;
    end
  endgenerate

endmodule

// File: rtl/irq_request_capture.sv
// IRR front end: per-line synchronise/filter, edge or level trigger,
// request latching with acknowledge, and set-freeze during INTA.
module irq_request_capture
  import pic_pkg::*;
#(
  parameter int NUM_IRQ       = PIC_NUM_IRQ,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] ir_in,
  input  logic               ltim,
  input  logic               icw1_wr,
  input  logic               freeze,
  input  logic               ack_valid,
  input  logic [2:0]         ack_idx,
  output logic [NUM_IRQ-1:0] irr,
  output logic               irq_any
);

  logic [NUM_IRQ-1:0] filt;
  logic [NUM_IRQ-1:0] prev_q;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] irr_q;
  logic [NUM_IRQ-1:0] ack_vec;
  logic [NUM_IRQ-1:0] set_ev;
  logic [NUM_IRQ-1:0] withdraw;
  logic [NUM_IRQ-1:0] clr_ev;
  irq_idx_t           ack_sel;

  generate
    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
      irq_line_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
      ) u_filter (
        .clk  (clk),
        .rst_n(rst_n),
        .ir   (ir_in[i]),
        .filt (filt[i])
      );
    end
  endgenerate

  assign ack_sel = ack_idx;

  // NOTE: every signal driven here gets a default before any branch so the
  // block stays purely combinational and no latch is inferred.
  always_comb begin
    ack_vec = '0;
    if (ack_valid && (int'(ack_sel) < NUM_IRQ)) ack_vec[ack_sel] = 1'b1;
  end

  // A level request being acked is suppressed for that one cycle so the
  // ack is visible; it re-sets on the next cycle if the line is still high.
  always_comb begin
    withdraw = '0;
    set_ev   = filt & ~prev_q;
    if (ltim == TRIG_LEVEL) begin
      withdraw = ~filt;
      set_ev   = filt & ~ack_vec;
    end
  end

  assign clr_ev = ack_vec | withdraw;

  // NOTE: every state flop, including the pending shadow, is cleared by the
  // asynchronous reset; none of it may come up holding a stale request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      pend_q <= '0;
      irr_q  <= '0;
    end else if (icw1_wr) begin
      prev_q <= '1;
      pend_q <= '0;
      irr_q  <= '0;
    end else begin
      prev_q <= filt;
      if (freeze) begin
        pend_q <= (pend_q | set_ev) & ~withdraw;
        irr_q  <= irr_q & ~clr_ev;
      end else begin
        pend_q <= '0;
        irr_q  <= ((irr_q | pend_q) & ~clr_ev) | set_ev;
      end
    end
  end

  assign irr     = irr_q;
  assign irq_any = |irr_q;

endmodule

// File: tb/tb_irq_request_capture.sv
// Directed scoreboard bench: stimulus queues expected irr per cycle, a
// negedge monitor pops and compares irr and irq_any.
module tb_irq_request_capture;

  logic       clk;
  logic       rst_n;
  logic [7:0] ir_in;
  logic       ltim;
  logic       icw1_wr;
  logic       freeze;
  logic       ack_valid;
  logic [2:0] ack_idx;
  logic [7:0] irr;
  logic       irq_any;

  irq_request_capture dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ir_in    (ir_in),
    .ltim     (ltim),
    .icw1_wr  (icw1_wr),
    .freeze   (freeze),
    .ack_valid(ack_valid),
    .ack_idx  (ack_idx),
    .irr      (irr),
    .irq_any  (irq_any)
  );

  typedef struct {
    int         cyc;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_vec   = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [7:0] act_irr,
                       input logic act_any, input logic [7:0] exp_irr);
    n_vec++;
    if (act_irr !== exp_irr || act_any !== (|exp_irr)) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: irr=%h irq_any=%b, required irr=%h irq_any=%b",
               name, cyc, act_irr, act_any, exp_irr, |exp_irr);
    end
  endtask

  // Monitor: compares every queued expectation due in the current cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check(sb[i].name, irr, irq_any, sb[i].exp);
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_vec++;
        n_fail++;
        $display("FAIL %s: expectation for cyc %0d never sampled (now %0d)",
                 sb[i].name, sb[i].cyc, cyc);
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int off, input logic [7:0] val, input string name);
    exp_t e;
    e.cyc  = cyc + off;
    e.exp  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack(input logic [2:0] idx);
    ack_valid = 1'b1;
    ack_idx   = idx;
    tick(1);
    ack_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    ir_in     = '0;
    ltim      = 1'b0;
    icw1_wr   = 1'b0;
    freeze    = 1'b0;
    ack_valid = 1'b0;
    ack_idx   = '0;
    tick(2);
    expect_at(0, 8'h00, "reset_state");
    tick(1);
    rst_n = 1'b1;
    tick(3);

    // Edge capture on line 3: five cycles from pin to irr.
    ir_in[3] = 1'b1;
    expect_at(4, 8'h00, "edge_pre");
    expect_at(5, 8'h08, "edge_capture");
    tick(6);
    ack(3'd3);
    expect_at(0, 8'h00, "edge_ack");
    expect_at(3, 8'h00, "edge_held_no_reset");
    tick(4);
    ir_in[3] = 1'b0;
    tick(8);

    // Glitch rejection then a 3-cycle pulse on line 5.
    ir_in[5] = 1'b1;
    tick(1);
    ir_in[5] = 1'b0;
    expect_at(6, 8'h00, "glitch_reject");
    tick(8);
    ir_in[5] = 1'b1;
    expect_at(4, 8'h00, "pulse_pre");
    expect_at(5, 8'h20, "pulse_capture");
    tick(3);
    ir_in[5] = 1'b0;
    tick(6);
    ack(3'd5);
    expect_at(0, 8'h00, "pulse_ack");
    tick(4);

    // Level mode on line 0: ack drops irr for one cycle, drop withdraws.
    ltim     = 1'b1;
    ir_in[0] = 1'b1;
    expect_at(5, 8'h01, "level_set");
    tick(7);
    ack(3'd0);
    expect_at(0, 8'h00, "level_ack_gap");
    expect_at(1, 8'h01, "level_reassert");
    tick(2);
    ir_in[0] = 1'b0;
    expect_at(4, 8'h01, "level_hold");
    expect_at(5, 8'h00, "level_withdraw");
    tick(6);
    ltim = 1'b0;
    tick(1);

    // Freeze: edge on line 6 is held back, ack of line 2 still applies.
    ir_in[2] = 1'b1;
    tick(6);
    expect_at(0, 8'h04, "freeze_setup");
    freeze = 1'b1;
    tick(1);
    ir_in[6] = 1'b1;
    expect_at(3, 8'h04, "freeze_hold_a");
    expect_at(5, 8'h04, "freeze_hold_b");
    tick(5);
    ack(3'd2);
    expect_at(0, 8'h00, "freeze_ack");
    expect_at(3, 8'h00, "freeze_hold_c");
    tick(3);
    freeze = 1'b0;
    tick(1);
    expect_at(0, 8'h40, "freeze_release");

    // ICW1 write clears irr; held line needs a fresh edge.
    ack(3'd6);
    expect_at(0, 8'h00, "icw1_prep_ack");
    ir_in[0] = 1'b1;
    ir_in[7] = 1'b1;
    tick(6);
    expect_at(0, 8'h81, "icw1_setup");
    icw1_wr   = 1'b1;
    ack_valid = 1'b1;
    ack_idx   = 3'd0;
    tick(1);
    icw1_wr   = 1'b0;
    ack_valid = 1'b0;
    expect_at(0, 8'h00, "icw1_clear");
    expect_at(6, 8'h00, "icw1_stays_clear");
    tick(8);
    ir_in[7] = 1'b0;
    tick(8);
    ir_in[7] = 1'b1;
    expect_at(4, 8'h00, "icw1_reedge_pre");
    expect_at(5, 8'h80, "icw1_reedge");
    tick(6);

    // Async reset with irr full and pending sets captured under freeze.
    ir_in = 8'h00;
    tick(8);
    ir_in = 8'hFF;
    expect_at(5, 8'hFF, "all_set");
    tick(6);
    freeze = 1'b1;
    ir_in  = 8'h00;
    tick(8);
    ir_in = 8'hFF;
    tick(6);
    #2;
    rst_n = 1'b0;
    expect_at(0, 8'h00, "async_reset");
    freeze = 1'b0;
    ir_in  = 8'h00;
    tick(2);
    rst_n = 1'b1;
    expect_at(4, 8'h00, "post_reset_no_pend");
    tick(6);
    ir_in[1] = 1'b1;
    expect_at(4, 8'h00, "post_reset_edge_pre");
    expect_at(5, 8'h02, "post_reset_edge");
    tick(6);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
